// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (core, ext)
// and the data memory. The arbiter takes the slave side; requesters/memory the master side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester data-memory port arbiter: core priority with starvation-forced ext grants.
// Optional perf counters enabled by defining DMEM_ARB_PERF_EN.

// Per-requester read response: captures memory data at the read-grant edge.
module dmem_rsp_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_gnt;
            if (rd_gnt) rdata <= mem_rdata;
        end
    end
endmodule

module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
`ifdef DMEM_ARB_PERF_EN
    , parameter int CNT_W      = 16
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    dmem_port_arbiter_if.slave bus,
    output logic               starved
`ifdef DMEM_ARB_PERF_EN
    , output logic [CNT_W-1:0] core_gnt_cnt
    , output logic [CNT_W-1:0] ext_gnt_cnt
    , output logic [CNT_W-1:0] conflict_cnt
`endif
);
    localparam int WC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_CORE_PRIO, ST_EXT_FORCE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            core_gnt, ext_gnt;
    req_t            core_r, ext_r, win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CORE_PRIO;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        core_gnt     = 1'b0;
        ext_gnt      = 1'b0;
        state_nxt    = ST_CORE_PRIO;
        wait_cnt_nxt = '0;
        if (reset_n) begin
            case (state)
                ST_CORE_PRIO: begin
                    core_gnt = bus.core_req;
                    ext_gnt  = bus.ext_req && !bus.core_req;
                end
                ST_EXT_FORCE: begin
                    ext_gnt  = bus.ext_req;
                    core_gnt = bus.core_req && !bus.ext_req;
                end
                default: ;
            endcase
        end
        if (bus.ext_req && !ext_gnt) begin
            if (wait_cnt == WC_W'(STARVE_LIMIT - 1)) state_nxt = ST_EXT_FORCE;
            else                                      wait_cnt_nxt = wait_cnt + 1'b1;
        end
    end

    assign starved = (state == ST_EXT_FORCE);

    assign core_r = '{we: bus.core_we, addr: bus.core_addr, wdata: bus.core_wdata};
    assign ext_r  = '{we: bus.ext_we,  addr: bus.ext_addr,  wdata: bus.ext_wdata};
    assign win    = ext_gnt ? ext_r : core_r;

    assign bus.core_gnt  = core_gnt;
    assign bus.ext_gnt   = ext_gnt;
    assign bus.mem_we    = (core_gnt || ext_gnt) && win.we;
    assign bus.mem_addr  = reset_n ? win.addr  : '0;
    assign bus.mem_wdata = reset_n ? win.wdata : '0;

    // Lane 0 serves the core, lane 1 the external master.
    logic [1:0]             rd_gnt;
    logic [1:0]             rvalid;
    logic [1:0][DATA_W-1:0] rdata;

    assign rd_gnt = {ext_gnt && !bus.ext_we, core_gnt && !bus.core_we};

    for (genvar l = 0; l < 2; l++) begin : g_rsp
        dmem_rsp_lane #(.DATA_W(DATA_W)) u_rsp (
            .clk       (clk),
            .reset_n   (reset_n),
            .rd_gnt    (rd_gnt[l]),
            .mem_rdata (bus.mem_rdata),
            .rvalid    (rvalid[l]),
            .rdata     (rdata[l])
        );
    end

    assign bus.core_rvalid = rvalid[0];
    assign bus.core_rdata  = rdata[0];
    assign bus.ext_rvalid  = rvalid[1];
    assign bus.ext_rdata   = rdata[1];

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_gnt_cnt <= '0;
            ext_gnt_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (core_gnt && !(&core_gnt_cnt)) core_gnt_cnt <= core_gnt_cnt + 1'b1;
            if (ext_gnt  && !(&ext_gnt_cnt))  ext_gnt_cnt  <= ext_gnt_cnt + 1'b1;
            if (bus.core_req && bus.ext_req && !(&conflict_cnt))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter with a rule-level reference model.
module tb_dmem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic starved;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_PERF_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] core_gnt_cnt, ext_gnt_cnt, conflict_cnt;
`endif

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
`ifdef DMEM_ARB_PERF_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .starved(starved)
`ifdef DMEM_ARB_PERF_EN
        , .core_gnt_cnt(core_gnt_cnt), .ext_gnt_cnt(ext_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    // Environment memory: combinational read, write at the grant edge.
    logic [31:0] mem_arr [256];
    assign bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;

    typedef struct { bit req; bit we; logic [31:0] addr; logic [31:0] wdata; } rq_t;
    typedef struct { int due; logic [31:0] data; } exp_t;

    rq_t         c, e;
    exp_t        sbq [2][$];
    logic [31:0] last_rd [2];
    logic [31:0] ref_mem [256];
    int          ext_denied = 0;
    bit          force_pri = 1'b0;
    int          checks = 0, failures = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic rq_t gen(int pct);
        rq_t r;
        r.req   = ($urandom_range(0, 99) < pct);
        r.we    = ($urandom_range(0, 2) == 0);
        r.addr  = 32'($urandom_range(0, 15));
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic drive();
        bus.core_req = c.req; bus.core_we = c.we; bus.core_addr = c.addr; bus.core_wdata = c.wdata;
        bus.ext_req  = e.req; bus.ext_we  = e.we; bus.ext_addr  = e.addr; bus.ext_wdata  = e.wdata;
    endtask

    task automatic model_reset();
        sbq[0].delete(); sbq[1].delete();
        last_rd[0] = '0; last_rd[1] = '0;
        ext_denied = 0; force_pri = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_core_gnt", bus.core_gnt, 0);    chk("rst_ext_gnt", bus.ext_gnt, 0);
        chk("rst_core_rvalid", bus.core_rvalid, 0); chk("rst_ext_rvalid", bus.ext_rvalid, 0);
        chk("rst_core_rdata", bus.core_rdata, 0); chk("rst_ext_rdata", bus.ext_rdata, 0);
        chk("rst_mem_we", bus.mem_we, 0);        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);  chk("rst_starved", starved, 0);
    endtask

    // One clock: drive, predict from the arbitration rules, compare, update model.
    task automatic step(output bit cg, output bit eg);
        bit   cw, ew;
        rq_t  w;
        exp_t x;
        @(posedge clk); #1;
        drive();
        #3;
        if (force_pri) begin ew = e.req; cw = c.req && !e.req; end
        else           begin cw = c.req; ew = e.req && !c.req; end
        w = ew ? e : c;
        chk("core_gnt", bus.core_gnt, cw);
        chk("ext_gnt", bus.ext_gnt, ew);
        chk("starved", starved, force_pri);
        chk("mem_we", bus.mem_we, (cw || ew) && w.we);
        chk("mem_addr", bus.mem_addr, w.addr);
        chk("mem_wdata", bus.mem_wdata, w.wdata);
        if (cw || ew) begin
            if (w.we) ref_mem[w.addr[7:0]] = w.wdata;
            else begin
                x.due = cyc + 1; x.data = ref_mem[w.addr[7:0]];
                sbq[ew ? 1 : 0].push_back(x);
            end
        end
        if (e.req && !ew) ext_denied++;
        else              ext_denied = 0;
        force_pri = (ext_denied >= STARVE_LIMIT);
        if (force_pri) ext_denied = 0;
        cg = bus.core_gnt;
        eg = bus.ext_gnt;
    endtask

    function automatic void mon_side(int s, logic rv, logic [31:0] rd);
        exp_t  x;
        string nm = (s == 1) ? "ext" : "core";
        if (rv) begin
            if (sbq[s].size() == 0) chk({nm, "_rvalid_spurious"}, rv, 0);
            else begin
                x = sbq[s].pop_front();
                chk({nm, "_rvalid_cycle"}, cyc, x.due);
                chk({nm, "_rdata"}, rd, x.data);
                last_rd[s] = x.data;
            end
        end else begin
            if (sbq[s].size() != 0 && sbq[s][0].due <= cyc) begin
                chk({nm, "_rvalid_missing"}, rv, 1);
                void'(sbq[s].pop_front());
            end
            chk({nm, "_rdata_hold"}, rd, last_rd[s]);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            mon_side(0, bus.core_rvalid, bus.core_rdata);
            mon_side(1, bus.ext_rvalid, bus.ext_rdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit cg, eg;
        int n_ext;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h3C00_0000 ^ (i * 32'h0001_0203);
            ref_mem[i] = 32'h3C00_0000 ^ (i * 32'h0001_0203);
        end
        mem_arr[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
        model_reset();
        // Reset with a live core request: grants and memory port must stay quiet.
        c = '{1'b1, 1'b0, 32'h44, 32'h1234}; e = '{1'b0, 1'b0, 32'h0, 32'h0};
        drive();
        repeat (2) @(posedge clk);
        #4 check_reset_outputs();
        c.req = 1'b0; drive();
        @(negedge clk); reset_n = 1'b1;

        // Core read of 0x10.
        c = '{1'b1, 1'b0, 32'h10, 32'h0};
        step(cg, eg);
        c.req = 1'b0;
        repeat (2) step(cg, eg);

        // External write 0x20 <- 0x55, no read response expected.
        e = '{1'b1, 1'b1, 32'h20, 32'h55};
        step(cg, eg);
        e.req = 1'b0;
        repeat (2) step(cg, eg);
        chk("ext_write_mem", mem_arr[8'h20], 32'h55);

        // Continuous conflict: ext forced every STARVE_LIMIT+1 cycles.
        c = gen(100); e = gen(100); n_ext = 0;
        for (int i = 0; i < 15; i++) begin
            step(cg, eg);
            n_ext += int'(eg);
            if (cg) c = gen(100);
            if (eg) e = gen(100);
        end
        chk("starve_pattern_ext_grants", n_ext, 3);
        c.req = 1'b0; e.req = 1'b0;
        step(cg, eg);

        // Ext starved 3 cycles then withdraws: the wait count must restart.
        c = gen(100); e = gen(100); e.we = 1'b0;
        repeat (3) begin step(cg, eg); if (cg) c = gen(100); end
        e.req = 1'b0;
        step(cg, eg); if (cg) c = gen(100);
        e.req = 1'b1; n_ext = 0;
        repeat (4) begin step(cg, eg); n_ext += int'(eg); if (cg) c = gen(100); end
        chk("no_early_force", n_ext, 0);
        step(cg, eg);
        c.req = 1'b0; e.req = 1'b0;
        step(cg, eg);

        // Randomized traffic at several request densities.
        for (int ph = 0; ph < 4; ph++) begin
            int pc, pe;
            pc = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 100;
            pe = (ph == 0) ? 90 : (ph == 1) ? 80 : (ph == 2) ? 20 : 30;
            c = gen(pc); e = gen(pe);
            for (int i = 0; i < 500; i++) begin
                step(cg, eg);
                if (cg || !c.req) c = gen(pc);
                if (eg || !e.req) e = gen(pe);
            end
        end

        // Reset in the cycle after a core read grant: the response is dropped.
        e.req = 1'b0;
        c = '{1'b1, 1'b0, 32'h10, 32'h0};
        step(cg, eg);
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_reset();
        #3 check_reset_outputs();
        repeat (2) @(posedge clk);
        #4 check_reset_outputs();
        c.req = 1'b0; drive();
        @(negedge clk); reset_n = 1'b1;
        repeat (3) step(cg, eg);

        // Fresh state after reset: 20 conflicting cycles starting from core priority.
        c = gen(100); e = gen(100); n_ext = 0;
        for (int i = 0; i < 20; i++) begin
            step(cg, eg);
            n_ext += int'(eg);
            if (cg) c = gen(100);
            if (eg) e = gen(100);
        end
        chk("post_reset_ext_grants", n_ext, 4);
        c.req = 1'b0; e.req = 1'b0;
        repeat (3) step(cg, eg);
`ifdef DMEM_ARB_PERF_EN
        chk("conflict_cnt_sat", conflict_cnt, 15);
        chk("core_gnt_cnt_sat", core_gnt_cnt, 15);
        chk("ext_gnt_cnt", ext_gnt_cnt, 4);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
